// File: rtl/m_mem_access.sv
// m_mem_access: M-stage load/store unit driving a req/ack data bus and stalling the pipeline until done.
// Optional ALIGN_EXC_EN adds exc/exc_code and traps misaligned half/word accesses.
module m_mem_access #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_load,
    input  logic        m_store,
    input  logic [1:0]  m_size,
    input  logic        m_sign,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] w_rdata,
`ifdef ALIGN_EXC_EN
    output logic        exc,
    output logic [4:0]  exc_code,
`endif
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic access, mis, tmo;
    logic [3:0] be;
    logic [31:0] wd, ld;
    logic [7:0] b;
    logic [15:0] h;
    assign access = m_valid & (m_load | m_store);
`ifdef ALIGN_EXC_EN
    assign mis = (m_size == 2'd1 & m_addr[0]) | (m_size[1] & |m_addr[1:0]);
`else
    assign mis = 1'b0;
`endif
    assign tmo = cnt == CNT_W'(TIMEOUT - 1);
    always_comb begin
        be = m_size == 2'd0 ? 4'b0001 << m_addr[1:0] : m_size == 2'd1 ? (m_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = m_size == 2'd0 ? {4{m_wdata[7:0]}} : m_size == 2'd1 ? {2{m_wdata[15:0]}} : m_wdata;
        b = mem_rdata[{m_addr[1:0], 3'b000} +: 8];
        h = m_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld = m_size == 2'd0 ? {{24{m_sign & b[7]}}, b} : m_size == 2'd1 ? {{16{m_sign & h[15]}}, h} : mem_rdata;
    end
    always_comb begin
        state_nx = state;
        stall = 1'b0;
        unique case (state)
            IDLE: begin
                stall = access;
                state_nx = access ? (mis ? DONE : REQ) : IDLE;
            end
            REQ: begin
                stall = 1'b1;
                state_nx = (mem_ack | tmo) ? DONE : REQ;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_be <= '0;
            mem_wdata <= '0;
            w_rdata <= '0;
            bus_err <= 1'b0;
`ifdef ALIGN_EXC_EN
            exc <= 1'b0;
            exc_code <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt <= state == REQ ? cnt + 1'b1 : '0;
            bus_err <= 1'b0;
            if (state == IDLE && access && !mis) begin
                mem_req <= 1'b1;
                mem_we <= m_store;
                mem_addr <= {m_addr[31:2], 2'b00};
                mem_be <= be;
                mem_wdata <= wd;
            end
            // ack beats a coincident timeout
            if (state == REQ && mem_ack) begin
                mem_req <= 1'b0;
                if (!m_store) w_rdata <= ld;
            end else if (state == REQ && tmo) begin
                mem_req <= 1'b0;
                w_rdata <= '0;
                bus_err <= 1'b1;
            end
`ifdef ALIGN_EXC_EN
            exc <= state == IDLE && access && mis;
            exc_code <= (state == IDLE && access && mis) ? (m_store ? 5'd5 : 5'd4) : 5'd0;
`endif
        end
    end
endmodule

// File: tb/tb_m_mem_access.sv
// tb_m_mem_access: vector table, hand sequences and random transactions against a transaction-level model.
module tb_m_mem_access;
    localparam int TO = 4;
    logic clk = 0, reset = 1;
    logic m_valid = 0, m_load = 0, m_store = 0, m_sign = 0;
    logic [1:0] m_size = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic mem_req, mem_we, mem_ack = 0, stall, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, w_rdata;
    logic [3:0] mem_be;
`ifdef ALIGN_EXC_EN
    logic exc;
    logic [4:0] exc_code;
`endif
    int n_chk = 0, n_fail = 0;
    logic [31:0] exp_w = 0;

    m_mem_access #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_load(m_load), .m_store(m_store),
        .m_size(m_size), .m_sign(m_sign), .m_addr(m_addr), .m_wdata(m_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .w_rdata(w_rdata),
`ifdef ALIGN_EXC_EN
        .exc(exc), .exc_code(exc_code),
`endif
        .bus_err(bus_err));

    always #5 clk = ~clk;

    typedef struct {
        logic ld, st, sign;
        logic [1:0] size;
        logic [31:0] addr, wdata, rdata;
        int dly;
        logic [31:0] e_addr, e_wd, e_w;
        logic [3:0] e_be;
        logic e_we, keep_w, e_berr;
        int e_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: whole-transaction outcome derived from byte/half/word arithmetic
    function automatic vec_t model(input vec_t v);
        int nb, sh;
        longint msk, val;
        nb = v.size == 0 ? 1 : v.size == 1 ? 2 : 4;
        sh = v.size == 0 ? 8 * int'(v.addr[1:0]) : v.size == 1 ? 16 * int'(v.addr[1]) : 0;
        v.e_addr = v.addr & 32'hFFFF_FFFC;
        v.e_be = 4'((2 ** nb - 1) << (sh / 8));
        v.e_wd = nb == 1 ? v.wdata[7:0] * 32'h0101_0101 : nb == 2 ? v.wdata[15:0] * 32'h0001_0001 : v.wdata;
        v.e_we = v.st;
        msk = (64'd1 << (8 * nb)) - 1;
        val = (longint'(v.rdata) >> sh) & msk;
        if (v.sign && nb < 4 && val >= (msk + 1) / 2) val = val - (msk + 1);
        v.e_berr = v.dly >= TO;
        v.e_stall = v.e_berr ? 1 + TO : 2 + v.dly;
        v.keep_w = v.st && !v.e_berr;
        v.e_w = v.e_berr ? 32'h0 : 32'(val);
        return v;
    endfunction

    task automatic run(input vec_t v);
        int n, rc;
        @(negedge clk);
        m_valid = 1; m_load = v.ld; m_store = v.st; m_size = v.size; m_sign = v.sign;
        m_addr = v.addr; m_wdata = v.wdata; mem_rdata = v.rdata; mem_ack = 0;
        n = 0; rc = 0;
        #1;
        while (stall && n < 40) begin
            n++;
            if (mem_req) begin
                if (rc == 0) begin
                    chk("mem_addr", mem_addr, v.e_addr);
                    chk("mem_be", 32'(mem_be), 32'(v.e_be));
                    chk("mem_we", 32'(mem_we), 32'(v.e_we));
                    chk("mem_wdata", mem_wdata, v.e_wd);
                end
                mem_ack = rc == v.dly;
                rc++;
            end else mem_ack = 0;
            @(negedge clk); #1;
        end
        mem_ack = 0;
        if (!v.keep_w) exp_w = v.e_w;
        chk("stall_cycles", 32'(n), 32'(v.e_stall));
        chk("bus_err", 32'(bus_err), 32'(v.e_berr));
        chk("req_dropped", 32'(mem_req), 0);
        chk("w_rdata", w_rdata, exp_w);
        m_valid = 0;
        @(negedge clk); #1;
        chk("bus_err_pulse", 32'(bus_err), 0);
        chk("idle_stall", 32'(stall), 0);
    endtask

    vec_t tbl[7];
    vec_t r;

    initial begin
        //            ld st sg sz   addr          wdata         rdata         dly e_addr        e_wd          e_w           e_be    we keep berr stall
        tbl[0] = '{0, 1, 0, 2'd2, 32'h0000_1006, 32'hDEAD_BEEF, 32'h0,        0,  32'h1004,     32'hDEAD_BEEF, 32'h0,       4'hF,   1, 1, 0, 2};
        tbl[1] = '{0, 1, 0, 2'd0, 32'h13,        32'hA5,        32'h0,        0,  32'h10,       32'hA5A5_A5A5, 32'h0,       4'h8,   1, 1, 0, 2};
        tbl[2] = '{1, 0, 1, 2'd0, 32'h21,        32'h0,         32'h1234_80FF, 2, 32'h20,       32'h0,        32'hFFFF_FF80, 4'h2,   0, 0, 0, 4};
        tbl[3] = '{1, 0, 0, 2'd1, 32'h22,        32'h0,         32'h8001_0000, 0, 32'h20,       32'h0,        32'h0000_8001, 4'hC,   0, 0, 0, 2};
        tbl[4] = '{1, 0, 0, 2'd2, 32'h40,        32'h0,         32'h1111_1111, 99, 32'h40,      32'h0,        32'h0,        4'hF,   0, 0, 1, 5};
        tbl[5] = '{1, 0, 0, 2'd2, 32'h44,        32'h0,         32'hCAFE_F00D, 3, 32'h44,       32'h0,        32'hCAFE_F00D, 4'hF,   0, 0, 0, 5};
        tbl[6] = '{0, 1, 0, 2'd3, 32'h0B,        32'h1122_3344, 32'h0,        1,  32'h08,       32'h1122_3344, 32'h0,       4'hF,   1, 1, 0, 3};
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_w_rdata", w_rdata, 0);
        chk("rst_stall", 32'(stall), 0);
        reset = 0;
        for (int i = 0; i < 7; i++) run(tbl[i]);
        // stray ack in IDLE and a non-valid load must do nothing
        @(negedge clk);
        m_valid = 0; m_load = 1; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
        #1 chk("invalid_no_stall", 32'(stall), 0);
        @(negedge clk); #1;
        chk("stray_ack_req", 32'(mem_req), 0);
        chk("stray_ack_w", w_rdata, exp_w);
        mem_ack = 0;
        // load and store together: store wins, w_rdata unchanged
        r = '{1, 1, 0, 2'd2, 32'h80, 32'h0BAD_F00D, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run(model(r));
        // reset during REQ, then a late ack
        exp_w = 32'hFFFF_FF80;
        run(tbl[2]);
        @(negedge clk);
        m_valid = 1; m_load = 1; m_store = 0; m_size = 2'd2; m_addr = 32'h100; mem_ack = 0;
        @(negedge clk); #1;
        chk("req_before_reset", 32'(mem_req), 1);
        reset = 1; m_valid = 0;
        @(negedge clk);
        reset = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
        #1;
        chk("rst_req_drop", 32'(mem_req), 0);
        chk("rst_req_stall", 32'(stall), 0);
        chk("rst_req_w", w_rdata, 0);
        @(negedge clk); #1;
        mem_ack = 0;
        chk("late_ack_w", w_rdata, 0);
        chk("late_ack_req", 32'(mem_req), 0);
        exp_w = 0;
        for (int i = 0; i < 40; i++) begin
            r.st = 1'($urandom);
            r.ld = r.st ? 1'($urandom) : 1'b1;
            r.sign = 1'($urandom);
            r.size = 2'($urandom);
            r.addr = $urandom;
            r.wdata = $urandom;
            r.rdata = $urandom;
            r.dly = $urandom_range(0, 6);
            run(model(r));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/m_mem_access.md
Name: m_mem_access

Overview:
- M-stage memory access unit; consumes the instruction fields registered into the M stage by the E→M pipeline register.
- Turns load/store requests into a req/ack data-memory bus transaction, stalling the pipeline until the access completes.
- Produces write data with byte enables for stores and extended read data for loads, registered for the W stage.

Parameters:
- TIMEOUT, 16: max cycles in REQ without ack before abort; must be ≥1.
- CNT_W, 5: width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- m_valid  in  1  M-stage slot holds a real instruction
- m_load  in  1  instruction is a load
- m_store  in  1  instruction is a store
- m_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- m_sign  in  1  load sign-extends when 1
- m_addr  in  32  effective address (ALU result)
- m_wdata  in  32  store data (rt value)
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  write strobe, valid with mem_req
- mem_addr  out  32  word-aligned address {m_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  single-cycle completion
- mem_rdata  in  32  read word, valid with mem_ack
- stall  out  1  freeze F/D/E/M and the E→M register
- w_rdata  out  32  extended load result, registered
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- access = m_valid & (m_load | m_store). If both load and store are set, store wins.
- States: IDLE, REQ, DONE. Reset forces IDLE, timeout counter 0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, w_rdata=0, bus_err=0.
- IDLE:
  - If access: register mem_req=1 plus mem_we/addr/be/wdata, go to REQ.
  - stall = access (combinational) in the same cycle.
  - No access: stall=0, stay in IDLE.
- REQ:
  - stall=1; bus outputs held constant; counter increments each cycle.
  - On mem_ack: mem_req←0, w_rdata←extended read (loads) or unchanged (stores), go to DONE.
  - If counter reaches TIMEOUT-1 with no ack: mem_req←0, w_rdata←0, bus_err=1 for one cycle, go to DONE.
  - If ack and timeout coincide, ack wins with no bus_err.
- DONE:
  - stall=0, so the pipeline advances at the end of this cycle.
  - Counter cleared; unconditional return to IDLE. A new access is seen only in IDLE.
- Latency: minimum 2 stall cycles (IDLE, REQ with same-cycle ack), then the DONE cycle.
- mem_ack outside REQ is ignored. A reset in REQ drops mem_req the next cycle; a later stray ack is ignored.
- Store lanes:
  - byte: be=4'b0001<<m_addr[1:0], wdata={4{m_wdata[7:0]}}
  - half: be = m_addr[1] ? 4'b1100 : 4'b0011, wdata={2{m_wdata[15:0]}}
  - word: be=4'b1111, wdata=m_wdata
- Loads: mem_we=0, mem_be computed as for stores.
  - byte: mem_rdata[8*a+7:8*a] with a=m_addr[1:0].
  - half: upper half if m_addr[1], else lower half.
  - Extension is by m_sign, to 32 bits.
- Misaligned addresses: low bits are ignored (half uses m_addr[1], word ignores [1:0]).

Optional Feature:
- Macro ALIGN_EXC_EN.
- When defined, adds output exc (1) and exc_code (5).
  - A half access with m_addr[0]=1, or a word access with m_addr[1:0]≠0, issues no bus request.
  - Goes IDLE→DONE directly, with stall=1 for that one IDLE cycle.
  - exc=1 in the DONE cycle; exc_code=4 for a load, 5 for a store; w_rdata unchanged.
  - exc and exc_code reset to 0.
- When undefined: ports absent; misaligned addresses are truncated as above.

Test Plan:
- Word store, addr 0x0000_1006, wdata 0xDEADBEEF, ack in first REQ cycle → mem_addr 0x1004, be 1111, we=1; stall high 2 cycles, then DONE.
- Byte store, addr 0x13, wdata 0x0000_00A5 → be 1000, mem_wdata 0xA5A5A5A5.
- Signed byte load, addr 0x21, rdata 0x1234_80FF, ack after 3 REQ cycles → w_rdata 0xFFFF_FF80; stall high 4 cycles.
- Unsigned half load, addr 0x22, rdata 0x8001_0000 → w_rdata 0x0000_8001.
- No ack with TIMEOUT=4 → mem_req drops after 4 REQ cycles, bus_err pulses once, w_rdata 0, pipeline resumes.
- Reset asserted in REQ, then ack one cycle later → state IDLE, mem_req 0, w_rdata 0, ack ignored, stall 0.
